// File: rtl/shift_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : shift_sequencer_if
//  Description : Request, result and shifter-side signals of shift_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface shift_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3,
    parameter int AMT_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;

    logic [WIDTH-1:0] bs_in;
    logic [CNT_W-1:0] bs_count;
    logic [WIDTH-1:0] bs_out;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       out_passes;
    logic             out_zero;

    // Sequencer side
    modport slave (
        input  in_valid, in_data, in_amt, bs_out, out_ready,
        output in_ready, bs_in, bs_count, out_valid, out_data, out_passes, out_zero
    );

    // Environment side: upstream producer, shifter and downstream consumer
    modport master (
        output in_valid, in_data, in_amt, bs_out, out_ready,
        input  in_ready, bs_in, bs_count, out_valid, out_data, out_passes, out_zero
    );
endinterface
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : shift_sequencer
//  Description : Applies a 0..31 right shift via repeated passes through an
//                external 0..7 barrel shifter, with valid/ready on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3,
    parameter int AMT_W = 5
) (
    input  wire logic          clk,
    input  wire logic          rst,
    shift_sequencer_if.slave   bus
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_shift = 2'd1;
    localparam logic [1:0] c_done  = 2'd2;

    localparam logic [CNT_W-1:0] c_max_count = '1;
    localparam logic [AMT_W-1:0] c_max_step  = {{(AMT_W-CNT_W){1'b0}}, c_max_count};

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_acc;
    logic [AMT_W-1:0] r_rem;
    logic [2:0]       r_passes;

    logic [CNT_W-1:0] w_count;
    logic [AMT_W-1:0] w_rem_next;
    logic             w_accept;

    // Largest legal pass; never exceeds r_rem, so r_rem cannot wrap.
    assign w_count    = (r_rem > c_max_step) ? c_max_count : r_rem[CNT_W-1:0];
    assign w_rem_next = r_rem - {{(AMT_W-CNT_W){1'b0}}, w_count};
    assign w_accept   = bus.in_valid && (r_state == c_idle);

    assign bus.in_ready   = (r_state == c_idle);
    assign bus.out_valid  = (r_state == c_done);
    assign bus.bs_in      = r_acc;
    assign bus.bs_count   = (r_state == c_shift) ? w_count : '0;
    assign bus.out_data   = r_acc;
    assign bus.out_passes = r_passes;
    assign bus.out_zero   = (r_acc == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_idle;
            r_acc    <= '0;
            r_rem    <= '0;
            r_passes <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_accept) begin
                        r_acc    <= bus.in_data;
                        r_rem    <= bus.in_amt;
                        r_passes <= '0;
                        r_state  <= (bus.in_amt == '0) ? c_done : c_shift;
                    end
                end
                c_shift: begin
                    r_acc    <= bus.bs_out;
                    r_rem    <= w_rem_next;
                    r_passes <= r_passes + 3'd1;
                    if (w_rem_next == '0) begin
                        r_state <= c_done;
                    end
                end
                c_done: begin
                    if (bus.out_ready) begin
                        r_state <= c_idle;
                    end
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    a_shift_has_work: assert property (@(posedge clk) disable iff (rst)
        (r_state == c_shift) |-> (r_rem != '0));

    a_done_holds: assert property (@(posedge clk) disable iff (rst)
        (r_state == c_done && !bus.out_ready) |=>
        (r_state == c_done && $stable(r_acc) && $stable(r_passes)));

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_sequencer
//  Description : Self-checking bench for shift_sequencer against a plain
//                arithmetic reference of the multi-pass right shift.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

    localparam int WIDTH = 8;
    localparam int CNT_W = 3;
    localparam int AMT_W = 5;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    shift_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W), .AMT_W(AMT_W)) bus ();

    // Behavioural barrel shifter: logical right, zero fill
    assign bus.bs_out = bus.bs_in >> bus.bs_count;

    shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W), .AMT_W(AMT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Entered and left at a falling edge with the DUT in IDLE.
    // While the result is held, optionally presents the next request.
    task automatic run_req(input logic [7:0] data, input int amt, input int hold,
                           input bit present, input logic [7:0] nd, input int na);
        int          steps[$];
        int          rem;
        int          passes;
        logic [7:0]  cur;
        logic [7:0]  exp_res;

        rem = amt;
        while (rem > 0) begin
            int s;
            s = (rem > 7) ? 7 : rem;
            steps.push_back(s);
            rem -= s;
        end
        passes  = (amt + 6) / 7;
        exp_res = (amt >= WIDTH) ? 8'h00 : (data >> amt);

        check("idle_in_ready", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_amt   = amt[AMT_W-1:0];
        cur          = data;

        for (int k = 1; k <= passes; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                bus.in_amt   = 5'($urandom);
            end
            check($sformatf("shift%0d_out_valid", k), bus.out_valid, 0);
            check($sformatf("shift%0d_in_ready", k), bus.in_ready, 0);
            check($sformatf("shift%0d_bs_count", k), bus.bs_count, steps[k-1]);
            check($sformatf("shift%0d_bs_in", k), bus.bs_in, cur);
            cur = cur >> steps[k-1];
        end

        @(negedge clk);
        if (passes == 0) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            bus.in_amt   = 5'($urandom);
        end
        check($sformatf("done_valid d=%0h a=%0d", data, amt), bus.out_valid, 1);
        check($sformatf("done_data d=%0h a=%0d", data, amt), bus.out_data, exp_res);
        check($sformatf("done_passes a=%0d", amt), bus.out_passes, passes);
        check("done_zero", bus.out_zero, (exp_res == 8'h00));
        check("done_bs_count", bus.bs_count, 0);
        check("done_in_ready", bus.in_ready, 0);

        if (present) begin
            bus.in_valid = 1'b1;
            bus.in_data  = nd;
            bus.in_amt   = na[AMT_W-1:0];
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", bus.out_valid, 1);
            check("hold_data", bus.out_data, exp_res);
            check("hold_passes", bus.out_passes, passes);
            check("hold_in_ready", bus.in_ready, 0);
        end

        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("release_out_valid", bus.out_valid, 0);
        check("release_in_ready", bus.in_ready, 1);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_amt    = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_passes", bus.out_passes, 0);
        check("rst_out_zero", bus.out_zero, 1);
        check("rst_bs_count", bus.bs_count, 0);
        rst = 1'b0;
        @(negedge clk);

        // Reset abort in the middle of a long request
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        bus.in_amt   = 5'd20;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("abort_pre_bs_count", bus.bs_count, 7);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("abort_rst_out_valid", bus.out_valid, 0);
        end
        rst = 1'b0;
        check("abort_in_ready", bus.in_ready, 1);
        check("abort_out_passes", bus.out_passes, 0);
        check("abort_bs_count", bus.bs_count, 0);
        repeat (4) begin
            @(negedge clk);
            check("abort_no_out_valid", bus.out_valid, 0);
            check("abort_idle", bus.in_ready, 1);
        end

        // Directed cases
        run_req(8'hB4, 0,  0, 1'b0, 8'h00, 0);
        run_req(8'hF0, 3,  0, 1'b0, 8'h00, 0);
        run_req(8'h80, 7,  0, 1'b0, 8'h00, 0);
        run_req(8'h80, 8,  0, 1'b0, 8'h00, 0);
        run_req(8'hFF, 31, 0, 1'b0, 8'h00, 0);
        // Backpressure with the next request presented during the hold
        run_req(8'hF0, 3,  4, 1'b1, 8'h55, 1);
        run_req(8'h55, 1,  0, 1'b0, 8'h00, 0);

        // Randomized requests
        for (int i = 0; i < 40; i++) begin
            logic [7:0] d;
            logic [7:0] nd;
            int         a;
            int         na;
            int         h;
            bit         p;
            d  = 8'($urandom);
            a  = int'($urandom_range(0, 31));
            h  = int'($urandom_range(0, 3));
            p  = 1'($urandom);
            nd = 8'($urandom);
            na = int'($urandom_range(0, 31));
            run_req(d, a, h, p, nd, na);
            if (p) begin
                run_req(nd, na, 0, 1'b0, 8'h00, 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
